// File: rtl/reg_bus_pkg.sv
// Shared types for the register-bus sequencer: command opcodes, FSM state
// encoding and the command legality rule used at acceptance.
package reg_bus_pkg;

  localparam logic OP_MOVE = 1'b0;
  localparam logic OP_SWAP = 1'b1;

  // IDLE waits for a command; MV is the single MOVE transfer; SW1..SW3 are
  // the three SWAP transfers through the temp register; ERR reports a reject.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MV   = 3'd1,
    SW1  = 3'd2,
    SW2  = 3'd3,
    SW3  = 3'd4,
    ERR  = 3'd5
  } state_e;

  // A command is legal when every index it uses names a real register and the
  // indices it uses are pairwise distinct (no register transfers onto itself).
  function automatic logic cmd_is_legal(
    input logic        op,
    input int unsigned a,
    input int unsigned b,
    input int unsigned t,
    input int unsigned nreg
  );
    logic in_range;
    logic distinct;
    if (op == OP_MOVE) begin
      in_range = (a < nreg) && (b < nreg);
      distinct = (a != b);
    end else begin
      in_range = (a < nreg) && (b < nreg) && (t < nreg);
      distinct = (a != b) && (a != t) && (b != t);
    end
    return in_range && distinct;
  endfunction

endpackage

// File: rtl/reg_bus_sequencer_idx_decoder.sv
// Register index to one-hot strobe decoder. The output is all-zero when the
// decoder is disabled or the index does not name an existing register.
module idx_decoder #(
  parameter int NREG = 4,
  parameter int IDXW = 2
) (
  input  logic [IDXW-1:0] idx,
  input  logic            en,
  output logic [NREG-1:0] onehot
);

  // Compare against each real register; out-of-range indices match nothing.
  always_comb begin
    // NOTE: default every combinational output first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    onehot = '0;
    for (int i = 0; i < NREG; i++) begin
      onehot[i] = en && (idx == IDXW'(i));
    end
  end

endmodule

// File: rtl/reg_bus_sequencer.sv
// Command-driven sequencer for a single shared register bus. Accepts MOVE and
// SWAP commands over valid/ready and issues one bus transfer per cycle as
// one-hot drive (rout) and load (rin) strobes. Only the IDLE state accepts a
// command, so at most one command is ever in flight.
module reg_bus_sequencer
  import reg_bus_pkg::*;
#(
  parameter int NREG = 4,
  parameter int IDXW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_op,
  input  logic [IDXW-1:0] cmd_a,
  input  logic [IDXW-1:0] cmd_b,
  input  logic [IDXW-1:0] cmd_t,
  output logic [NREG-1:0] rout,
  output logic [NREG-1:0] rin,
  output logic            busy,
  output logic            done,
  output logic            err
);

  state_e          state_q, state_d;
  logic [IDXW-1:0] a_q, a_d;
  logic [IDXW-1:0] b_q, b_d;
  logic [IDXW-1:0] t_q, t_d;

  logic            accept;
  logic            legal;

  logic            rout_en, rin_en;
  logic [IDXW-1:0] rout_idx, rin_idx;

  // Handshake: ready only while idle; legality judged on the live fields.
  assign cmd_ready = (state_q == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign legal     = cmd_is_legal(cmd_op, 32'(cmd_a), 32'(cmd_b), 32'(cmd_t),
                                  32'(NREG));

  // State and command-field registers; reset aborts any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      t_q     <= t_d;
    end
  end

  // Capture the command fields only on the accepting edge; hold otherwise.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    t_d = t_q;
    if (accept) begin
      a_d = cmd_a;
      b_d = cmd_b;
      t_d = cmd_t;
    end
  end

  // Next-state logic: each transfer state lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!legal)                state_d = ERR;
          else if (cmd_op == OP_SWAP) state_d = SW1;
          else                        state_d = MV;
        end
      end
      MV:      state_d = IDLE;
      SW1:     state_d = SW2;
      SW2:     state_d = SW3;
      SW3:     state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode: which register drives, which loads, and the pulses.
  // SWAP goes t <= Y, then Y <= X, then X <= t.
  always_comb begin
    rout_en  = 1'b0;
    rin_en   = 1'b0;
    rout_idx = '0;
    rin_idx  = '0;
    done     = 1'b0;
    err      = 1'b0;
    case (state_q)
      MV: begin
        rout_en  = 1'b1;
        rout_idx = a_q;
        rin_en   = 1'b1;
        rin_idx  = b_q;
        done     = 1'b1;
      end
      SW1: begin
        rout_en  = 1'b1;
        rout_idx = b_q;
        rin_en   = 1'b1;
        rin_idx  = t_q;
      end
      SW2: begin
        rout_en  = 1'b1;
        rout_idx = a_q;
        rin_en   = 1'b1;
        rin_idx  = b_q;
      end
      SW3: begin
        rout_en  = 1'b1;
        rout_idx = t_q;
        rin_en   = 1'b1;
        rin_idx  = a_q;
        done     = 1'b1;
      end
      ERR: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: begin
        rout_en = 1'b0;
        rin_en  = 1'b0;
      end
    endcase
  end

  assign busy = (state_q != IDLE);

  idx_decoder #(.NREG(NREG), .IDXW(IDXW)) u_rout_dec (
    .idx    (rout_idx),
    .en     (rout_en),
    .onehot (rout)
  );

  idx_decoder #(.NREG(NREG), .IDXW(IDXW)) u_rin_dec (
    .idx    (rin_idx),
    .en     (rin_en),
    .onehot (rin)
  );

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Scoreboard bench for reg_bus_sequencer. The driver pushes the expected
// per-cycle strobes and the expected register file into a queue when a command
// is accepted; a negedge monitor pops and compares against the DUT and a
// behavioural bus/register datapath driven by the DUT strobes.
`timescale 1ns/1ps
module tb_reg_bus_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_op = 1'b0;
  logic [1:0] cmd_a = '0, cmd_b = '0, cmd_t = '0;
  logic [3:0] rout, rin;
  logic       busy, done, err;

  logic       cmd_valid3 = 1'b0;
  logic       cmd_ready3;
  logic       cmd_op3 = 1'b0;
  logic [1:0] cmd_a3 = '0, cmd_b3 = '0, cmd_t3 = '0;
  logic [2:0] rout3, rin3;
  logic       busy3, done3, err3;

  always #5 clk = ~clk;

  reg_bus_sequencer #(.NREG(4), .IDXW(2)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_t(cmd_t),
    .rout(rout), .rin(rin), .busy(busy), .done(done), .err(err)
  );

  reg_bus_sequencer #(.NREG(3), .IDXW(2)) dut3 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_op(cmd_op3), .cmd_a(cmd_a3), .cmd_b(cmd_b3), .cmd_t(cmd_t3),
    .rout(rout3), .rin(rin3), .busy(busy3), .done(done3), .err(err3)
  );

  typedef struct packed {
    logic [3:0]      rout;
    logic [3:0]      rin;
    logic            done;
    logic            err;
    logic            last;
    logic [31:0]     due;
    logic [3:0][7:0] regs;
  } beat_t;

  beat_t           exp_q[$];
  int              n_chk = 0;
  int              n_pass = 0;
  int              cyc = 0;
  logic            mon_en = 1'b0;
  logic            reg_pend = 1'b0;
  logic [3:0][7:0] reg_exp = '0;

  logic [7:0]      dp [4];
  logic [7:0]      mdl [4];
  logic [7:0]      init_vals [4];
  logic            dp_init = 1'b0;
  logic [7:0]      bus;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Shared bus: OR of all driving registers.
  always_comb begin
    bus = '0;
    for (int i = 0; i < 4; i++) if (rout[i]) bus = bus | dp[i];
  end

  // Register file datapath controlled by the DUT strobes.
  always @(posedge clk) begin
    if (dp_init) begin
      for (int i = 0; i < 4; i++) dp[i] <= init_vals[i];
    end else begin
      for (int i = 0; i < 4; i++) if (rin[i]) dp[i] <= bus;
    end
  end

  function automatic logic [3:0] oh(input logic [1:0] i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  function automatic logic legal_ref(input logic op, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] t);
    if (op == 1'b0) return a != b;
    return (a != b) && (b != t) && (a != t);
  endfunction

  // Expected beats for one accepted command; also advances the register model.
  task automatic push_expect(input logic op, input logic [1:0] a,
                             input logic [1:0] b, input logic [1:0] t);
    beat_t      bt;
    logic [7:0] va, vb;
    bt = '0;
    bt.due = 32'(cyc + 1);
    if (!legal_ref(op, a, b, t)) begin
      bt.done = 1'b1;
      bt.err  = 1'b1;
      bt.last = 1'b1;
      for (int i = 0; i < 4; i++) bt.regs[i] = mdl[i];
      exp_q.push_back(bt);
    end else if (op == 1'b0) begin
      mdl[b] = mdl[a];
      bt.rout = oh(a);
      bt.rin  = oh(b);
      bt.done = 1'b1;
      bt.last = 1'b1;
      for (int i = 0; i < 4; i++) bt.regs[i] = mdl[i];
      exp_q.push_back(bt);
    end else begin
      va = mdl[a];
      vb = mdl[b];
      mdl[t] = vb;
      mdl[b] = va;
      mdl[a] = vb;
      bt.rout = oh(b); bt.rin = oh(t);
      exp_q.push_back(bt);
      bt.due = 32'(cyc + 2);
      bt.rout = oh(a); bt.rin = oh(b);
      exp_q.push_back(bt);
      bt.due = 32'(cyc + 3);
      bt.rout = oh(t); bt.rin = oh(a); bt.done = 1'b1; bt.last = 1'b1;
      for (int i = 0; i < 4; i++) bt.regs[i] = mdl[i];
      exp_q.push_back(bt);
    end
  endtask

  // Present a command and hold it until the DUT accepts it (bounded).
  task automatic send(input logic op, input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] t, output int acc_cyc);
    int waited;
    waited = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_t = t;
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      check("send_timeout", 64'(cmd_ready), 64'(1));
      cmd_valid = 1'b0;
      acc_cyc = -1;
    end else begin
      push_expect(op, a, b, t);
      acc_cyc = cyc;
      @(posedge clk);
    end
  endtask

  task automatic release_bus();
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while ((exp_q.size() != 0 || reg_pend) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    check("drain_queue_empty", 64'(exp_q.size()), 64'(0));
  endtask

  // Monitor: compare each cycle against the scoreboard and the invariants.
  always @(negedge clk) begin
    beat_t e;
    if (mon_en) begin
      check("invariant_onehot0_noself",
            64'($onehot0(rout) && $onehot0(rin) && ((rout & rin) == 4'b0)), 64'(1));
      if (reg_pend) begin
        check("regs", {32'b0, dp[3], dp[2], dp[1], dp[0]}, {32'b0, reg_exp});
        reg_pend <= 1'b0;
      end
      if (exp_q.size() != 0 && exp_q[0].due < 32'(cyc)) begin
        e = exp_q.pop_front();
        check("missed_beat", 64'(cyc), 64'(e.due));
      end else if (exp_q.size() != 0 && exp_q[0].due == 32'(cyc)) begin
        e = exp_q.pop_front();
        check("beat", {51'b0, busy, cmd_ready, rout, rin, done, err},
              {51'b0, 1'b1, 1'b0, e.rout, e.rin, e.done, e.err});
        if (e.last) begin
          reg_pend <= 1'b1;
          reg_exp  <= e.regs;
        end
      end else begin
        check("idle_quiet", {51'b0, busy, cmd_ready, rout, rin, done, err},
              {51'b0, 1'b0, 1'b1, 4'b0, 4'b0, 1'b0, 1'b0});
      end
    end
  end

  // One command into the NREG=3 instance with hand-computed response.
  task automatic dut3_cmd(input string nm, input logic op, input logic [1:0] a,
                          input logic [1:0] b, input logic [1:0] t,
                          input logic [2:0] er, input logic [2:0] ei,
                          input logic ee);
    @(negedge clk);
    check({nm, "_ready"}, 64'(cmd_ready3), 64'(1));
    cmd_valid3 = 1'b1; cmd_op3 = op; cmd_a3 = a; cmd_b3 = b; cmd_t3 = t;
    @(negedge clk);
    cmd_valid3 = 1'b0;
    check(nm, {55'b0, busy3, rout3, rin3, done3, err3},
          {55'b0, 1'b1, er, ei, 1'b1, ee});
    @(negedge clk);
    check({nm, "_after"}, {61'b0, busy3, cmd_ready3, done3},
          {61'b0, 1'b0, 1'b1, 1'b0});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, c2;

    // Reset state while asserted.
    @(negedge clk);
    check("reset_state", {51'b0, rout, rin, busy, done, err, cmd_ready},
          {51'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    rst = 1'b0;

    // Test 1: reset in SW2 aborts the SWAP at once.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_a = 2'd0; cmd_b = 2'd1; cmd_t = 2'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("pre_reset_sw1", {56'b0, rout, rin}, {56'b0, 4'b0010, 4'b0100});
    @(negedge clk);
    check("pre_reset_sw2", {56'b0, rout, rin}, {56'b0, 4'b0001, 4'b0010});
    rst = 1'b1;
    #1;
    check("reset_mid_swap", {52'b0, rout, rin, busy, cmd_ready},
          {52'b0, 4'b0, 4'b0, 1'b0, 1'b1});
    @(negedge clk);
    check("reset_held", {51'b0, rout, rin, busy, cmd_ready, done},
          {51'b0, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0});
    rst = 1'b0;
    @(negedge clk);
    check("reset_after", {50'b0, rout, rin, busy, cmd_ready, done, err},
          {50'b0, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0, 1'b0});

    // Load R = {5, 9, 0, 0} into datapath and model.
    init_vals[0] = 8'd5; init_vals[1] = 8'd9; init_vals[2] = 8'd0; init_vals[3] = 8'd0;
    for (int i = 0; i < 4; i++) mdl[i] = init_vals[i];
    dp_init = 1'b1;
    @(negedge clk);
    dp_init = 1'b0;
    mon_en = 1'b1;

    // Test 3: SWAP 0,1 via temp 2.
    send(1'b1, 2'd0, 2'd1, 2'd2, c0);
    release_bus();
    drain();
    check("swap_r0", 64'(dp[0]), 64'(9));
    check("swap_r1", 64'(dp[1]), 64'(5));

    // Test 2: MOVE 1 -> 3.
    send(1'b0, 2'd1, 2'd3, 2'd0, c0);
    release_bus();
    drain();
    check("move_r3", 64'(dp[3]), 64'(5));

    // Test 4: illegal commands, back to back.
    send(1'b0, 2'd2, 2'd2, 2'd0, c0);
    send(1'b1, 2'd1, 2'd1, 2'd3, c0);
    send(1'b1, 2'd0, 2'd2, 2'd0, c0);
    release_bus();
    drain();

    // Test 5a: fields change while busy; held MOVE accepted right after done.
    send(1'b1, 2'd2, 2'd3, 2'd0, c0);
    @(negedge clk);
    cmd_op = 1'b0; cmd_a = 2'd0; cmd_b = 2'd3;
    check("ready_low_busy", 64'(cmd_ready), 64'(0));
    @(negedge clk);
    cmd_op = 1'b1; cmd_a = 2'd3; cmd_b = 2'd1; cmd_t = 2'd2;
    send(1'b0, 2'd3, 2'd0, 2'd0, c1);
    release_bus();
    drain();
    check("held_accept_gap", 64'(c1 - c0), 64'(4));

    // Test 5b: MOVE-SWAP-MOVE stream at maximum rate.
    send(1'b0, 2'd0, 2'd1, 2'd0, c0);
    send(1'b1, 2'd1, 2'd2, 2'd3, c1);
    send(1'b0, 2'd2, 2'd0, 2'd0, c2);
    release_bus();
    drain();
    check("stream_move_gap", 64'(c1 - c0), 64'(2));
    check("stream_swap_gap", 64'(c2 - c1), 64'(4));

    // NREG = 3 instance: out-of-range index is rejected.
    dut3_cmd("n3_move_idx3", 1'b0, 2'd0, 2'd3, 2'd0, 3'b000, 3'b000, 1'b1);
    dut3_cmd("n3_swap_t3",   1'b1, 2'd0, 2'd1, 2'd3, 3'b000, 3'b000, 1'b1);
    dut3_cmd("n3_move_ok",   1'b0, 2'd2, 2'd0, 2'd1, 3'b100, 3'b001, 1'b0);

    // Test 6: random command stream with occasional idle gaps.
    for (int n = 0; n < 1000; n++) begin
      send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), c0);
      if ($urandom_range(0, 3) == 0) release_bus();
    end
    release_bus();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
